// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC generator: prioritised next-PC select (reset, exception, redirect,
// stall, RAS return prediction, sequential) plus EPC capture and a circular return-address stack.
module pc_fetch_ctrl #(
   parameter int          N         = 32,
   parameter logic [N-1:0] RESET_VEC = 32'h003F_FFFC,
   parameter logic [N-1:0] EXC_VEC   = 32'h8000_0180,
   parameter int          STEP      = 4,
   parameter int          RAS_DEPTH = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         stall,
   input  logic                         exc_valid,
   input  logic                         redirect_valid,
   input  logic [N-1:0]                 redirect_target,
   input  logic                         call_push,
   input  logic [N-1:0]                 call_ret_addr,
   input  logic                         ret_pop,
   output logic [N-1:0]                 pc_out,
   output logic                         pc_valid,
   output logic [N-1:0]                 epc,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
   output logic                         ras_full,
   output logic                         ras_empty
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;

   logic [N-1:0]  pc_q, pc_d;
   logic          valid_q;
   logic [N-1:0]  epc_q, epc_d;
   logic [N-1:0]  ras_q [RAS_DEPTH];
   logic [N-1:0]  ras_d [RAS_DEPTH];
   logic [PW-1:0] ptr_q, ptr_d, ptr_inc;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          empty, full;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(RAS_DEPTH));
   assign ptr_inc = ptr_q + PW'(1);

   always_comb begin
      pc_d  = pc_q;
      epc_d = epc_q;
      ras_d = ras_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (exc_valid) begin
         pc_d  = EXC_VEC;
         epc_d = pc_q;
         ptr_d = '0;
         cnt_d = '0;
      end else if (redirect_valid) begin
         pc_d = redirect_target & ~N'(3);
      end else if (!stall) begin
         if (ret_pop && !empty) begin
            pc_d = ras_q[ptr_q];
            // Call+return together: replace the top in place, depth unchanged.
            if (call_push) begin
               ras_d[ptr_q] = call_ret_addr;
            end else begin
               ptr_d = ptr_q - PW'(1);
               cnt_d = cnt_q - CW'(1);
            end
         end else begin
            pc_d = pc_q + N'(STEP);
            if (call_push) begin
               ras_d[ptr_inc] = call_ret_addr;
               ptr_d          = ptr_inc;
               if (!full) cnt_d = cnt_q + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q    <= RESET_VEC;
         valid_q <= 1'b0;
         epc_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      end else begin
         pc_q    <= pc_d;
         valid_q <= 1'b1;
         epc_q   <= epc_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         ras_q   <= ras_d;
      end
   end

   assign pc_out    = pc_q;
   assign pc_valid  = valid_q;
   assign epc       = epc_q;
   assign ras_count = cnt_q;
   assign ras_full  = full;
   assign ras_empty = empty;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: queue-based RAS reference model feeds a scoreboard of
// per-cycle expectations, plus fixed-value spot checks from the directed scenarios.
module tb_pc_fetch_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        exc_valid = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        call_push = 1'b0;
   logic [31:0] call_ret_addr = '0;
   logic        ret_pop = 1'b0;
   logic [31:0] pc_out;
   logic        pc_valid;
   logic [31:0] epc;
   logic [2:0]  ras_count;
   logic        ras_full;
   logic        ras_empty;

   pc_fetch_ctrl dut (
      .clock(clock), .reset(reset), .stall(stall), .exc_valid(exc_valid),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .call_push(call_push), .call_ret_addr(call_ret_addr), .ret_pop(ret_pop),
      .pc_out(pc_out), .pc_valid(pc_valid), .epc(epc), .ras_count(ras_count),
      .ras_full(ras_full), .ras_empty(ras_empty)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] pc;
      logic        valid;
      logic [31:0] epc;
      int          cnt;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] m_pc, m_epc;
   logic        m_valid;
   logic [31:0] m_ras [$];
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Reference model: the RAS is a queue whose back is the top; oldest dropped from the front.
   task automatic cycle(input logic rst, input logic stl, input logic exc, input logic red,
                        input logic [31:0] tgt, input logic push, input logic [31:0] ra,
                        input logic pop);
      exp_t e;
      if (rst) begin
         m_pc = 32'h003F_FFFC; m_valid = 1'b0; m_epc = '0; m_ras.delete();
      end else begin
         m_valid = 1'b1;
         if (exc) begin
            m_epc = m_pc; m_pc = 32'h8000_0180; m_ras.delete();
         end else if (red) begin
            m_pc = {tgt[31:2], 2'b00};
         end else if (!stl) begin
            if (pop && m_ras.size() > 0) begin
               m_pc = m_ras[m_ras.size()-1];
               if (push) m_ras[m_ras.size()-1] = ra;
               else void'(m_ras.pop_back());
            end else begin
               m_pc = m_pc + 32'd4;
               if (push) begin
                  if (m_ras.size() == 4) void'(m_ras.pop_front());
                  m_ras.push_back(ra);
               end
            end
         end
      end
      e.pc = m_pc; e.valid = m_valid; e.epc = m_epc; e.cnt = m_ras.size();
      sb.push_back(e);
      reset = rst; stall = stl; exc_valid = exc; redirect_valid = red;
      redirect_target = tgt; call_push = push; call_ret_addr = ra; ret_pop = pop;
      @(posedge clock);
      #1;
      e = sb.pop_front();
      chk("pc_out", pc_out, e.pc);
      chk("pc_valid", {31'd0, pc_valid}, {31'd0, e.valid});
      chk("epc", epc, e.epc);
      chk("ras_count", {29'd0, ras_count}, 32'(e.cnt));
      chk("ras_full", {31'd0, ras_full}, {31'd0, e.cnt == 4});
      chk("ras_empty", {31'd0, ras_empty}, {31'd0, e.cnt == 0});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, '0, 0, '0, 0);
   endtask

   initial begin
      #2;
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, '0, 0, '0, 0);
      chk("rst_pc", pc_out, 32'h003F_FFFC);
      chk("rst_valid", {31'd0, pc_valid}, 32'd0);
      idle(1);
      chk("first_pc", pc_out, 32'h0040_0000);
      chk("first_valid", {31'd0, pc_valid}, 32'd1);
      idle(4);
      chk("seq_pc", pc_out, 32'h0040_0010);

      cycle(0, 1, 0, 0, '0, 0, '0, 0);
      cycle(0, 1, 0, 0, '0, 0, '0, 0);
      chk("stall_hold", pc_out, 32'h0040_0010);
      cycle(0, 1, 0, 0, '0, 1, 32'h0000_0900, 0);
      chk("stall_push", {29'd0, ras_count}, 32'd0);

      cycle(0, 0, 0, 1, 32'h0040_0123, 1, 32'h0000_0a00, 0);
      chk("redir_align", pc_out, 32'h0040_0120);
      cycle(0, 0, 0, 1, 32'h0040_003C, 0, '0, 0);
      cycle(0, 0, 0, 0, '0, 1, 32'h0000_0b00, 0);
      chk("pre_exc_pc", pc_out, 32'h0040_0040);
      cycle(0, 0, 1, 1, 32'h0040_0200, 0, '0, 0);
      chk("exc_pc", pc_out, 32'h8000_0180);
      chk("exc_epc", epc, 32'h0040_0040);
      chk("exc_ras", {29'd0, ras_count}, 32'd0);

      for (int i = 1; i <= 5; i++) cycle(0, 0, 0, 0, '0, 1, 32'(i * 256), 0);
      chk("ras_full5", {31'd0, ras_full}, 32'd1);
      for (int i = 5; i >= 2; i--) begin
         cycle(0, 0, 0, 0, '0, 0, '0, 1);
         chk("ras_pop_pc", pc_out, 32'(i * 256));
      end
      cycle(0, 0, 0, 0, '0, 0, '0, 1);
      chk("pop_empty_pc", pc_out, 32'h0000_0204);
      chk("pop_empty", {31'd0, ras_empty}, 32'd1);

      cycle(0, 0, 0, 0, '0, 1, 32'h0000_0100, 0);
      cycle(0, 0, 0, 0, '0, 1, 32'h0000_0700, 1);
      chk("swap_pc", pc_out, 32'h0000_0100);
      chk("swap_cnt", {29'd0, ras_count}, 32'd1);
      cycle(0, 0, 0, 0, '0, 0, '0, 1);
      chk("swap_pop", pc_out, 32'h0000_0700);

      cycle(0, 0, 0, 1, 32'hFFFF_FFFC, 0, '0, 0);
      idle(1);
      chk("wrap_pc", pc_out, 32'h0000_0000);

      cycle(1, 1, 1, 1, 32'h1234_5678, 1, 32'h55, 1);
      chk("midrst_pc", pc_out, 32'h003F_FFFC);
      idle(2);

      for (int i = 0; i < 80; i++)
         cycle(($urandom % 25) == 0, ($urandom % 5) == 0, ($urandom % 12) == 0,
               ($urandom % 7) == 0, $urandom, ($urandom % 3) == 0, $urandom,
               ($urandom % 3) == 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
